uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
Parametrised full-duplex UART core, the successor to the fixed 8N1 switch/LED test UART. Data width, stop-bit count, baud divisor and RX buffering are set at elaboration. Both directions use valid/ready handshakes, so the core can sit directly behind a bus slave or a debug monitor. RX buffering uses a small FIFO. Framing and overrun errors are reported as one-cycle pulses.

Parameters:
DATA_BITS, 8, payload bits per frame, legal range 5..8, sent and received LSB first
STOP_BITS, 1, stop bits transmitted, 1 or 2; RX always checks only the first stop bit
CLK_FREQ, 100000000, clk_i frequency in Hz
BAUDRATE, 115200, line rate; DIV = CLK_FREQ/BAUDRATE (integer truncation), HALF = DIV/2; DIV >= 4 required
RX_FIFO_DEPTH, 4, RX FIFO entries, power of two, >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
rx_i  in  1  serial input, asynchronous to clk_i
tx_o  out  1  serial output, idle high
tx_data_i  in  DATA_BITS  byte to send
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  transmitter idle, can accept a byte
rx_data_o  out  DATA_BITS  FIFO head, valid when rx_valid_o=1
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  consumer pops the head
rx_frame_err_o  out  1  one-cycle pulse: bad stop bit
rx_overrun_o  out  1  one-cycle pulse: byte dropped, FIFO full
parity_err_o  out  1  one-cycle pulse: parity mismatch (tied 0 without UART_PARITY_EN)

Behaviour:
- Reset and clock: rst_i asynchronous, active-high; clock clk_i. All registers reset, including those in the middle of a frame.
- Reset values: tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, all error pulses 0. The FIFO is emptied and both FSMs enter IDLE.
- Reset mid-frame: tx_o returns high immediately (asynchronously), and any partial RX byte is discarded.
- rx_i synchronisation: rx_i passes through a 2-flop synchroniser (reset value 1). All RX logic uses the synchronised signal.
- TX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - tx_ready_o=1 only in IDLE.
  - Handshake when tx_valid_i & tx_ready_o: tx_data_i is latched, and tx_o goes low on the next clock edge.
  - Each bit is held exactly DIV cycles. STOP holds tx_o=1 for STOP_BITS*DIV cycles, then the FSM enters IDLE.
  - Minimum spacing between frames is one IDLE cycle. tx_data_i changes during a frame are ignored.
- RX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE -> START when the synchronised rx line is 0.
  - START waits HALF cycles, then samples. If the line is 1, the event is a glitch: go to IDLE with no pulse.
  - DATA and PARITY each sample DIV cycles after the previous sample.
  - STOP samples DIV cycles after the last sample. If 1 (and parity is OK), the byte is pushed to the FIFO. If 0, rx_frame_err_o pulses and the byte is discarded.
  - The FSM returns to IDLE right after the stop-bit sample, so back-to-back frames are received.
- RX FIFO:
  - First-word-fall-through: rx_data_o is the head, rx_valid_o = not empty.
  - Pop occurs when rx_valid_o & rx_ready_i.
  - The push from a completed frame appears on rx_valid_o/rx_data_o one cycle after the stop-bit sample.
  - Push when full with no pop in the same cycle: the new byte is dropped, rx_overrun_o pulses, and FIFO contents are unchanged.
  - Push when full with a pop in the same cycle: both happen and the count is unchanged.
  - Push and pop in the same cycle when empty: the push is stored and the pop is ignored (valid was 0).
  - Pointers wrap modulo RX_FIFO_DEPTH; the count is log2(depth)+1 bits wide.
- Counters: the baud counter is wide enough for DIV. Comparisons are to 0 after a down-count, with reload to DIV-1 on bit boundaries, so each bit period is exactly DIV cycles.
- Error pulses are mutually exclusive per frame, with priority: parity > frame > overrun.

Optional Feature:
UART_PARITY_EN
- Defined:
  - Adds parameter PARITY_ODD (default 0, i.e. even parity).
  - TX inserts one parity bit after the data bits: the XOR of the data bits, inverted if PARITY_ODD.
  - RX samples the parity bit one DIV after the last data bit. On mismatch, parity_err_o pulses and the byte is not pushed, even if the stop bit is good.
- Undefined:
  - No parity bit on TX or RX and no PARITY state.
  - parity_err_o is tied 0.

Test Plan:
Setup for all scenarios: CLK_FREQ=1000000, BAUDRATE=100000 (DIV=10, HALF=5), DATA_BITS=8, STOP_BITS=1, RX_FIFO_DEPTH=4, no parity unless noted.
1. TX 0xA5 handshake at cycle T -> tx_o=0 over [T+1,T+10], then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles; tx_ready_o=0 for exactly 100 cycles, then 1.
2. tx_o looped to rx_i, TX 0x3C with rx_ready_i=1 -> rx_valid_o pulses one cycle with rx_data_o=0x3C; no error pulses.
3. rx_i low for 3 cycles, then high -> no rx_valid_o, no error pulses; a following valid 0x81 frame is received correctly.
4. 0x55 frame driven with stop bit 0 -> rx_frame_err_o is a single-cycle pulse, rx_valid_o stays 0; the next good frame 0xAA is received.
5. rx_ready_i=0, frames 0x01..0x05 back-to-back -> rx_overrun_o pulses once on the 5th frame; then rx_ready_i=1 reads 0x01,0x02,0x03,0x04, then rx_valid_o=0.
6. UART_PARITY_EN, PARITY_ODD=0: TX 0x07 -> parity bit 1 emitted. RX 0x07 with parity bit 0 -> parity_err_o pulses and nothing is pushed. Reset asserted mid-TX -> tx_o=1 immediately and tx_ready_o=1.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART, valid/ready on both sides, FWFT RX FIFO.
// Optional parity bit (PARITY_ODD parameter) when UART_PARITY_EN is defined.
module uart_core_param #(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int CLK_FREQ      = 100000000,
  parameter int BAUDRATE      = 115200,
  parameter int RX_FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
  ,
  parameter int PARITY_ODD    = 0
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_overrun_o,
  output logic                 parity_err_o
);
  localparam int DIV = CLK_FREQ / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW = $clog2(STOP_BITS * DIV + 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] STOP_LD = CW'(STOP_BITS * DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;
  state_t tx_state, tx_state_n, rx_state, rx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [IW-1:0] tx_idx, tx_idx_n, rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
  logic tx_o_n, tx_tick, rx_tick, rx_meta, rx_s, stop_smp, rx_bad, rx_push;
  logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic full, pop, wr;
  assign tx_ready_o = tx_state == S_IDLE;
  assign tx_tick = tx_cnt == '0;
  assign rx_tick = rx_cnt == '0;
`ifdef UART_PARITY_EN
  logic tx_par, tx_par_n, rx_perr, rx_perr_n, par_q;
  assign rx_bad = rx_perr;
  assign parity_err_o = par_q;
  assign tx_o_n = tx_state_n == S_START ? 1'b0 : tx_state_n == S_DATA ? tx_sh_n[0] :
                  tx_state_n == S_PAR ? tx_par_n : 1'b1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tx_par <= 1'b0;
      rx_perr <= 1'b0;
      par_q <= 1'b0;
    end else begin
      tx_par <= tx_par_n;
      rx_perr <= rx_perr_n;
      par_q <= stop_smp & rx_perr;
    end
`else
  assign rx_bad = 1'b0;
  assign parity_err_o = 1'b0;
  assign tx_o_n = tx_state_n == S_START ? 1'b0 : tx_state_n == S_DATA ? tx_sh_n[0] : 1'b1;
`endif
  // tx_o is registered from next-state so the line is glitch-free and resets high at once
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tx_state <= S_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
      tx_o <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= tx_cnt_n;
      tx_idx <= tx_idx_n;
      tx_sh <= tx_sh_n;
      tx_o <= tx_o_n;
    end
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n = tx_tick ? tx_cnt : tx_cnt - CW'(1);
    tx_idx_n = tx_idx;
    tx_sh_n = tx_sh;
`ifdef UART_PARITY_EN
    tx_par_n = tx_par;
`endif
    case (tx_state)
      S_IDLE: if (tx_valid_i) begin
        tx_state_n = S_START;
        tx_cnt_n = BIT_LD;
        tx_sh_n = tx_data_i;
`ifdef UART_PARITY_EN
        tx_par_n = (^tx_data_i) ^ (PARITY_ODD != 0);
`endif
      end
      S_START: if (tx_tick) begin
        tx_state_n = S_DATA;
        tx_cnt_n = BIT_LD;
        tx_idx_n = '0;
      end
      S_DATA: if (tx_tick) begin
        tx_sh_n = tx_sh >> 1;
        tx_idx_n = tx_idx + IW'(1);
        tx_cnt_n = BIT_LD;
        if (tx_idx == LAST) begin
`ifdef UART_PARITY_EN
          tx_state_n = S_PAR;
`else
          tx_state_n = S_STOP;
          tx_cnt_n = STOP_LD;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: if (tx_tick) begin
        tx_state_n = S_STOP;
        tx_cnt_n = STOP_LD;
      end
`endif
      S_STOP: if (tx_tick) tx_state_n = S_IDLE;
      default: tx_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      rx_frame_err_o <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_s <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt <= rx_cnt_n;
      rx_idx <= rx_idx_n;
      rx_sh <= rx_sh_n;
      rx_frame_err_o <= stop_smp & ~rx_bad & ~rx_s;
      rx_overrun_o <= rx_push & full & ~pop;
    end
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n = rx_tick ? rx_cnt : rx_cnt - CW'(1);
    rx_idx_n = rx_idx;
    rx_sh_n = rx_sh;
    stop_smp = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_n = rx_perr;
`endif
    case (rx_state)
      S_IDLE: if (!rx_s) begin
        rx_state_n = S_START;
        rx_cnt_n = HALF_LD;
      end
      S_START: if (rx_tick) begin
        rx_state_n = rx_s ? S_IDLE : S_DATA;
        rx_cnt_n = BIT_LD;
        rx_idx_n = '0;
      end
      S_DATA: if (rx_tick) begin
        rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
        rx_idx_n = rx_idx + IW'(1);
        rx_cnt_n = BIT_LD;
`ifdef UART_PARITY_EN
        if (rx_idx == LAST) rx_state_n = S_PAR;
      end
      S_PAR: if (rx_tick) begin
        rx_perr_n = rx_s ^ (^rx_sh) ^ (PARITY_ODD != 0);
        rx_state_n = S_STOP;
        rx_cnt_n = BIT_LD;
`else
        if (rx_idx == LAST) rx_state_n = S_STOP;
`endif
      end
      S_STOP: if (rx_tick) begin
        rx_state_n = S_IDLE;
        stop_smp = 1'b1;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end
  assign rx_push = stop_smp & rx_s & ~rx_bad;
  assign full = cnt == (AW+1)'(RX_FIFO_DEPTH);
  assign pop = rx_valid_o & rx_ready_i;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
  assign wr = rx_push & (~full | pop);
  assign rx_valid_o = cnt != '0;
  assign rx_data_o = mem[rp];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) mem[wp] <= rx_sh;
      wp <= wp + AW'(wr);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: directed UART bench with an RX scoreboard and error-pulse monitor.
module tb_uart_core_param;
  logic clk, rst, rx_drv, loop, tx_valid, rx_ready;
  logic [7:0] tx_data;
  logic tx_o, tx_ready_o, rx_valid_o, rx_frame_err_o, rx_overrun_o, parity_err_o;
  logic [7:0] rx_data_o;
  logic rx_i;
  int checks = 0, errors = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic pf = 0, po = 0, pp = 0;
  logic [7:0] sbq[$];
  logic [7:0] e;
  assign rx_i = loop ? tx_o : rx_drv;
  uart_core_param #(
    .DATA_BITS(8), .STOP_BITS(1), .CLK_FREQ(1000000), .BAUDRATE(100000), .RX_FIFO_DEPTH(4)
`ifdef UART_PARITY_EN
    , .PARITY_ODD(0)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_i), .tx_o(tx_o), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready), .rx_frame_err_o(rx_frame_err_o),
    .rx_overrun_o(rx_overrun_o), .parity_err_o(parity_err_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      pf = 0;
      po = 0;
      pp = 0;
    end else begin
      if (rx_valid_o && rx_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected got %0h required none", rx_data_o);
        end else begin
          e = sbq.pop_front();
          chk("rx_data", 32'(rx_data_o), 32'(e));
        end
      end
      if (rx_frame_err_o) begin n_ferr++; chk("ferr_single", 32'(pf), 0); end
      if (rx_overrun_o) begin n_ovr++; chk("ovr_single", 32'(po), 0); end
      if (parity_err_o) begin n_perr++; chk("perr_single", 32'(pp), 0); end
      pf = rx_frame_err_o;
      po = rx_overrun_o;
      pp = parity_err_o;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    rx_drv = 0;
    cyc(10);
    for (int k = 0; k < 8; k++) begin
      rx_drv = d[k];
      cyc(10);
    end
`ifdef UART_PARITY_EN
    rx_drv = ^d;
    cyc(10);
`endif
    rx_drv = stop;
    cyc(10);
    rx_drv = 1;
  endtask
  task automatic tx_send(input logic [7:0] d);
    chk("tx_ready_pre", 32'(tx_ready_o), 1);
    tx_data = d;
    tx_valid = 1;
    @(posedge clk);
    #1;
    tx_valid = 0;
    tx_data = ~d;
  endtask
  task automatic tx_check(input logic [10:0] bits, input int ns);
    for (int s = 0; s < ns; s++)
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("tx_line", 32'({tx_ready_o, tx_o}), 32'({1'b0, bits[s]}));
      end
    @(negedge clk);
    chk("tx_idle", 32'({tx_ready_o, tx_o}), 32'(2'b11));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1);
  end
  initial begin
    rst = 1; rx_drv = 1; loop = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
    cyc(3);
    chk("rst_tx", 32'({tx_o, tx_ready_o}), 32'(2'b11));
    chk("rst_rx", 32'({rx_valid_o, rx_data_o}), 0);
    chk("rst_err", 32'({rx_frame_err_o, rx_overrun_o, parity_err_o}), 0);
    rst = 0;
    cyc(3);
    tx_send(8'hA5);
`ifdef UART_PARITY_EN
    tx_check(11'b10101001010, 11);
`else
    tx_check(11'b01101001010, 10);
`endif
    loop = 1;
    rx_ready = 1;
    sbq.push_back(8'h3C);
    tx_send(8'h3C);
    cyc(140);
    chk("t2_drain", sbq.size(), 0);
    chk("t2_err", n_ferr + n_ovr + n_perr, 0);
    loop = 0;
    cyc(5);
    rx_drv = 0;
    cyc(3);
    rx_drv = 1;
    cyc(20);
    sbq.push_back(8'h81);
    send(8'h81, 1);
    cyc(20);
    chk("t3_drain", sbq.size(), 0);
    chk("t3_err", n_ferr + n_ovr + n_perr, 0);
    sbq.push_back(8'hAA);
    send(8'h55, 0);
    cyc(30);
    chk("t4_ferr", n_ferr, 1);
    chk("t4_novalid", 32'(rx_valid_o), 0);
    send(8'hAA, 1);
    cyc(20);
    chk("t4_drain", sbq.size(), 0);
    chk("t4_ferr_after", n_ferr, 1);
    rx_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) sbq.push_back(8'(i));
      send(8'(i), 1);
    end
    cyc(20);
    chk("t5_ovr", n_ovr, 1);
    chk("t5_full_valid", 32'({rx_valid_o, rx_data_o}), 32'({1'b1, 8'h01}));
    rx_ready = 1;
    cyc(10);
    chk("t5_drain", sbq.size(), 0);
    chk("t5_empty", 32'(rx_valid_o), 0);
    chk("t5_ferr_perr", n_ferr + n_perr, 1);
`ifdef UART_PARITY_EN
    tx_send(8'h07);
    tx_check(11'b11000001110, 11);
    rx_drv = 0;
    cyc(10);
    for (int k = 0; k < 8; k++) begin
      rx_drv = k < 3;
      cyc(10);
    end
    rx_drv = 0;
    cyc(10);
    rx_drv = 1;
    cyc(20);
    chk("t6_perr", n_perr, 1);
    chk("t6_nopush", 32'(rx_valid_o), 0);
    chk("t6_ferr", n_ferr, 1);
`else
    chk("t6_noperr", n_perr, 0);
`endif
    tx_send(8'h5A);
    cyc(30);
    chk("t6_mid_tx", 32'({tx_o, tx_ready_o}), 0);
    rst = 1;
    #1;
    chk("t6_rst_async", 32'({tx_o, tx_ready_o}), 32'(2'b11));
    cyc(2);
    rst = 0;
    cyc(5);
    chk("t6_post_rst", 32'({tx_o, tx_ready_o, rx_valid_o}), 32'(3'b110));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
